// File: rtl/onehot_check_core.sv
// Consistency checker for a one-hot select vector against the address and enable
// that produced it. Reusable wherever a decoded select must be cross-checked.
module onehot_check_core #(
  parameter int AddrWidth   = 5,
  parameter int OneHotWidth = 2 ** AddrWidth,
  parameter bit AddrCheck   = 1'b1,
  parameter bit EnableCheck = 1'b1,
  parameter bit StrictCheck = 1'b1
) (
  input  logic [OneHotWidth-1:0] oh_i,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic                   en_i,
  output logic                   err_o
);

  localparam int N  = 2 ** AddrWidth;
  localparam int IW = (AddrWidth > 0) ? AddrWidth : 1;
  localparam logic [AddrWidth:0] OhLimit = (AddrWidth + 1)'(OneHotWidth);

  if (OneHotWidth < 1 || OneHotWidth > N) begin : g_bad_width
    $error("onehot_check_core: OneHotWidth must lie in 1..2**AddrWidth");
  end
  if (AddrCheck && !EnableCheck) begin : g_bad_checks
    $error("onehot_check_core: AddrCheck requires EnableCheck");
  end

  // Balanced pairwise reduction; each node carries {two-or-more set, any set}.
  function automatic logic [1:0] reduce_tree(input logic [N-1:0] v);
    logic [N-1:0] any_v;
    logic [N-1:0] multi_v;
    any_v   = v;
    multi_v = '0;
    for (int w = N; w > 1; w = w / 2) begin
      for (int j = 0; j < w / 2; j++) begin
        multi_v[IW'(j)] = multi_v[IW'(2*j)] | multi_v[IW'(2*j+1)]
                        | (any_v[IW'(2*j)] & any_v[IW'(2*j+1)]);
        any_v[IW'(j)]   = any_v[IW'(2*j)] | any_v[IW'(2*j+1)];
      end
    end
    return {multi_v[0], any_v[0]};
  endfunction

  // Mux tree steered by address bits, LSB first, so the selected bit is found
  // without re-encoding the address.
  function automatic logic sel_tree(input logic [N-1:0] v, input logic [AddrWidth-1:0] a);
    logic [N-1:0]           s;
    logic [AddrWidth-1:0]   a_sh;
    s    = v;
    a_sh = a;
    for (int w = N; w > 1; w = w / 2) begin
      for (int j = 0; j < w / 2; j++) begin
        s[IW'(j)] = a_sh[0] ? s[IW'(2*j+1)] : s[IW'(2*j)];
      end
      a_sh = a_sh >> 1;
    end
    return s[0];
  endfunction

  logic [N-1:0] oh_pad;
  logic         multi_hot;
  logic         any_hot;
  logic         en_err;
  logic         addr_err;

  assign oh_pad               = N'(oh_i);
  assign {multi_hot, any_hot} = reduce_tree(oh_pad);

  if (EnableCheck) begin : g_en_chk
    assign en_err = (!en_i && any_hot) || (StrictCheck && en_i && !any_hot);
  end else begin : g_no_en_chk
    assign en_err = 1'b0;
  end

  if (AddrCheck) begin : g_addr_chk
    logic addr_oob;
    assign addr_oob = ({1'b0, addr_i} >= OhLimit);
    assign addr_err = en_i && (addr_oob || !sel_tree(oh_pad, addr_i));
  end else begin : g_no_addr_chk
    assign addr_err = 1'b0;
  end

  assign err_o = multi_hot | en_err | addr_err;

endmodule

// File: rtl/onehot_guarded_decoder.sv
// Binary-to-one-hot decoder with an independently checked buffered copy, used as a
// fault countermeasure on register-file select decoding.
module onehot_guarded_decoder #(
  parameter int AddrWidth   = 5,
  parameter int OneHotWidth = 2 ** AddrWidth,
  parameter bit AddrCheck   = 1'b1,
  parameter bit EnableCheck = 1'b1,
  parameter bit StrictCheck = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic                   en_i,
  input  logic [OneHotWidth-1:0] fault_i,
  output logic [OneHotWidth-1:0] oh_o,
  output logic                   err_o,
  output logic                   err_sticky_o
);

  for (genvar i = 0; i < OneHotWidth; i++) begin : g_enc
    assign oh_o[i] = en_i & (addr_i == AddrWidth'(i));
  end

  // Kept as a distinct net so the checker cannot be folded back into the encoder.
  (* keep = "true", dont_touch = "true" *) logic [OneHotWidth-1:0] oh_buf;
  assign oh_buf = oh_o;

  logic [OneHotWidth-1:0] oh_chk;
  assign oh_chk = oh_buf ^ fault_i;

  onehot_check_core #(
    .AddrWidth   (AddrWidth),
    .OneHotWidth (OneHotWidth),
    .AddrCheck   (AddrCheck),
    .EnableCheck (EnableCheck),
    .StrictCheck (StrictCheck)
  ) u_check (
    .oh_i   (oh_chk),
    .addr_i (addr_i),
    .en_i   (en_i),
    .err_o  (err_o)
  );

  logic err_sticky_d;
  logic err_sticky_q;

  assign err_sticky_d = err_sticky_q | err_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_sticky_q <= 1'b0;
    end else begin
      err_sticky_q <= err_sticky_d;
    end
  end

  assign err_sticky_o = err_sticky_q;

endmodule

// File: tb/tb_onehot_guarded_decoder.sv
// Directed bench for onehot_guarded_decoder: three parameterisations share one
// stimulus stream, expectations come from a popcount-based reference model.
module tb_onehot_guarded_decoder;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [4:0]  addr;
  logic        en;
  logic [31:0] fault;

  logic [31:0] oh, oh_ns;
  logic [19:0] oh20;
  logic        err, err_ns, err20;
  logic        st, st_ns, st20;

  always #5 clk_i = ~clk_i;

  onehot_guarded_decoder dut (
    .clk_i (clk_i), .rst_ni (rst_ni), .addr_i (addr), .en_i (en),
    .fault_i (fault), .oh_o (oh), .err_o (err), .err_sticky_o (st)
  );

  onehot_guarded_decoder #(.AddrCheck(1'b0), .StrictCheck(1'b0)) dut_ns (
    .clk_i (clk_i), .rst_ni (rst_ni), .addr_i (addr), .en_i (en),
    .fault_i (fault), .oh_o (oh_ns), .err_o (err_ns), .err_sticky_o (st_ns)
  );

  onehot_guarded_decoder #(.OneHotWidth(20)) dut_w20 (
    .clk_i (clk_i), .rst_ni (rst_ni), .addr_i (addr), .en_i (en),
    .fault_i (fault[19:0]), .oh_o (oh20), .err_o (err20), .err_sticky_o (st20)
  );

  typedef struct packed {
    logic [31:0] oh;
    logic        err;
    logic        st;
    logic        err_ns;
    logic        st_ns;
    logic [31:0] oh20;
    logic        err20;
    logic        st20;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  logic st_m, st_ns_m, st20_m;

  function automatic logic [31:0] model_oh(logic [4:0] a, logic e, int w);
    logic [31:0] r;
    r = '0;
    if (e && int'(a) < w) r[a] = 1'b1;
    return r;
  endfunction

  function automatic logic model_err(logic [4:0] a, logic e, logic [31:0] f, int w,
                                     bit ac, bit ec, bit sc);
    logic [31:0] mask, chk;
    int          cnt;
    logic        r;
    mask = 32'((64'(1) << w) - 64'(1));
    chk  = (model_oh(a, e, w) ^ f) & mask;
    cnt  = $countones(chk);
    r    = (cnt > 1);
    if (ec && !e && cnt > 0) r = 1'b1;
    if (ec && sc && e && cnt == 0) r = 1'b1;
    if (ac && e) begin
      if (int'(a) >= w) r = 1'b1;
      else if (!chk[a]) r = 1'b1;
    end
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_total++;
    assert (act === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, act, exp);
  endtask

  task automatic compare(string tag);
    exp_t x;
    x = sb.pop_front();
    chk({tag, ".oh"},     oh,                 x.oh);
    chk({tag, ".err"},    32'(err),           32'(x.err));
    chk({tag, ".st"},     32'(st),            32'(x.st));
    chk({tag, ".oh_ns"},  oh_ns,              x.oh);
    chk({tag, ".err_ns"}, 32'(err_ns),        32'(x.err_ns));
    chk({tag, ".st_ns"},  32'(st_ns),         32'(x.st_ns));
    chk({tag, ".oh20"},   32'(oh20),          x.oh20);
    chk({tag, ".err20"},  32'(err20),         32'(x.err20));
    chk({tag, ".st20"},   32'(st20),          32'(x.st20));
  endtask

  task automatic push_exp();
    exp_t x;
    x.oh     = model_oh(addr, en, 32);
    x.err    = model_err(addr, en, fault, 32, 1, 1, 1);
    x.st     = st_m;
    x.err_ns = model_err(addr, en, fault, 32, 0, 1, 0);
    x.st_ns  = st_ns_m;
    x.oh20   = model_oh(addr, en, 20);
    x.err20  = model_err(addr, en, fault, 20, 1, 1, 1);
    x.st20   = st20_m;
    sb.push_back(x);
  endtask

  // One combinational observation per cycle; sticky models advance at the next edge.
  task automatic step(string tag, logic [4:0] a, logic e, logic [31:0] f);
    @(negedge clk_i);
    addr  = a;
    en    = e;
    fault = f;
    push_exp();
    #1;
    compare(tag);
    st_m    = st_m    | model_err(a, e, f, 32, 1, 1, 1);
    st_ns_m = st_ns_m | model_err(a, e, f, 32, 0, 1, 0);
    st20_m  = st20_m  | model_err(a, e, f, 20, 1, 1, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    st_m    = 1'b0;
    st_ns_m = 1'b0;
    st20_m  = 1'b0;
    rst_ni  = 1'b0;
    addr    = '0;
    en      = 1'b0;
    fault   = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    push_exp();
    #1;
    compare("reset");
    rst_ni = 1'b1;

    step("addr3", 5'd3, 1'b1, 32'h0);
    for (int a = 0; a < 32; a++) step($sformatf("sweep%0d", a), 5'(a), 1'b1, 32'h0);

    step("en0_clean", 5'd7, 1'b0, 32'h0);
    step("en0_fault", 5'd7, 1'b0, 32'h1);
    step("en0_unfault", 5'd7, 1'b0, 32'h0);
    step("sticky_hold", 5'd7, 1'b0, 32'h0);

    step("two_hot", 5'd5, 1'b1, 32'h0000_0001);
    step("zero_hot", 5'd5, 1'b1, 32'h0000_0020);

    step("oob_en1", 5'd25, 1'b1, 32'h0);
    step("oob_en0", 5'd25, 1'b0, 32'h0);

    step("pre_rst", 5'd7, 1'b0, 32'h1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rst_async.st",    32'(st),    32'h0);
    chk("rst_async.st_ns", 32'(st_ns), 32'h0);
    chk("rst_async.st20",  32'(st20),  32'h0);
    chk("rst_async.err",   32'(err),   32'h1);
    st_m    = 1'b0;
    st_ns_m = 1'b0;
    st20_m  = 1'b0;
    fault   = 32'h0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    step("rst_rel", 5'd7, 1'b0, 32'h0);
    step("rst_hold", 5'd2, 1'b1, 32'h0);
    step("rearm_err", 5'd3, 1'b1, 32'h100);
    step("rearm_st", 5'd3, 1'b1, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
